// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: start bit, LSB-first data, optional even parity, stop bit.
// One word is taken per frame over a valid/ready handshake; every line-side output is registered.
module piso_serializer #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_serial,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cyc;
  logic [BW-1:0]         r_bit;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par;
  logic                  r_serial;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_accept;
  logic                  w_bit_end;
  logic [DATA_WIDTH-1:0] w_shift_nxt;

  assign tx_ready    = (r_state == IDLE) && !reset;
  assign w_accept    = tx_ready && tx_valid;
  assign w_bit_end   = (r_cyc == CNT_LAST);
  assign w_shift_nxt = r_shift >> 1;

  assign tx_serial = r_serial;
  assign tx_busy   = r_busy;
  assign tx_done   = r_done;

  // r_serial is loaded with the level of the bit that starts at this edge,
  // so the line changes in the same cycle the state does.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cyc    <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_serial <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state  <= START;
            r_cyc    <= '0;
            r_bit    <= '0;
            r_shift  <= tx_data;
            r_par    <= ^tx_data;
            r_serial <= 1'b0;
            r_busy   <= 1'b1;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_state  <= DATA;
            r_cyc    <= '0;
            r_serial <= r_shift[0];
          end else begin
            r_cyc <= r_cyc + 1'b1;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_cyc <= '0;
            if (r_bit == BIT_LAST) begin
              r_bit <= '0;
              if (PARITY_EN != 0) begin
                r_state  <= PARITY;
                r_serial <= r_par;
              end else begin
                r_state  <= STOP;
                r_serial <= 1'b1;
              end
            end else begin
              r_bit    <= r_bit + 1'b1;
              r_shift  <= w_shift_nxt;
              r_serial <= w_shift_nxt[0];
            end
          end else begin
            r_cyc <= r_cyc + 1'b1;
          end
        end
        PARITY: begin
          if (w_bit_end) begin
            r_state  <= STOP;
            r_cyc    <= '0;
            r_serial <= 1'b1;
          end else begin
            r_cyc <= r_cyc + 1'b1;
          end
        end
        STOP: begin
          if (w_bit_end) begin
            r_state  <= IDLE;
            r_cyc    <= '0;
            r_serial <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end else begin
            r_cyc <= r_cyc + 1'b1;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_serial <= 1'b1;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: three instances (4 clk/bit with parity, 4 clk/bit without, 1 clk/bit with)
// checked every cycle against a frame-timeline model, plus table vectors and hand-written sequences.
module tb_piso_serializer;

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] valid = 3'b111;
  logic [7:0] din [3] = '{8'hA5, 8'hA5, 8'hA5};
  wire  [2:0] ser, bsy, dn, rdy;

  int n_vec = 0;
  int n_bad = 0;

  logic [2:0] ls [128];
  logic [2:0] bs [128];
  logic [2:0] ds [128];

  always #5 clk = ~clk;

  piso_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) u0 (
    .clk(clk), .reset(reset), .tx_data(din[0]), .tx_valid(valid[0]),
    .tx_ready(rdy[0]), .tx_serial(ser[0]), .tx_busy(bsy[0]), .tx_done(dn[0]));
  piso_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) u1 (
    .clk(clk), .reset(reset), .tx_data(din[1]), .tx_valid(valid[1]),
    .tx_ready(rdy[1]), .tx_serial(ser[1]), .tx_busy(bsy[1]), .tx_done(dn[1]));
  piso_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(1), .PARITY_EN(1)) u2 (
    .clk(clk), .reset(reset), .tx_data(din[2]), .tx_valid(valid[2]),
    .tx_ready(rdy[2]), .tx_serial(ser[2]), .tx_busy(bsy[2]), .tx_done(dn[2]));

  function automatic int cpb(int i);
    return (i == 2) ? 1 : 4;
  endfunction

  function automatic int pen(int i);
    return (i == 1) ? 0 : 1;
  endfunction

  function automatic int flen(int i);
    return (2 + 8 + pen(i)) * cpb(i);
  endfunction

  // Line level of bit slot idx of a frame: start, 8 data LSB first, optional parity, stop.
  function automatic logic fbit(logic [7:0] d, int pe, int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (pe != 0 && idx == 9) return ^d;
    return 1'b1;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: t = cycles since the accepting edge (-1 when idle); t == frame length is the done cycle.
  int         t [3] = '{-1, -1, -1};
  logic [7:0] md [3];

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) t[i] = -1;
      else if ((t[i] == -1 || t[i] == flen(i)) && valid[i]) begin
        t[i]  = 0;
        md[i] = din[i];
      end else if (t[i] == flen(i)) t[i] = -1;
      else if (t[i] >= 0) t[i] = t[i] + 1;
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      logic es, eb, ed, er;
      es = 1'b1; eb = 1'b0; ed = 1'b0;
      if (t[i] >= 0 && t[i] < flen(i)) begin
        es = fbit(md[i], pen(i), t[i] / cpb(i));
        eb = 1'b1;
      end else if (t[i] == flen(i)) begin
        ed = 1'b1;
      end
      er = (t[i] == -1 || t[i] == flen(i)) && !reset;
      chk($sformatf("u%0d serial t=%0d", i, t[i]), ser[i], es);
      chk($sformatf("u%0d busy t=%0d", i, t[i]), bsy[i], eb);
      chk($sformatf("u%0d done t=%0d", i, t[i]), dn[i], ed);
      chk($sformatf("u%0d ready t=%0d", i, t[i]), rdy[i], er);
    end
  end

  task automatic capture(int base, int n);
    for (int k = base; k < base + n; k++) begin
      ls[k] = ser; bs[k] = bsy; ds[k] = dn;
      @(negedge clk);
    end
  endtask

  task automatic send(int i, logic [7:0] v);
    @(negedge clk);
    din[i]   = v;
    valid[i] = 1'b1;
    @(negedge clk);
    valid[i] = 1'b0;
  endtask

  function automatic logic [7:0] get_byte(int i, int base, int c);
    logic [7:0] b;
    for (int j = 0; j < 8; j++) b[j] = ls[base + (j + 1) * c + c / 2][i];
    return b;
  endfunction

  function automatic int cnt_busy(int i, int lo, int hi);
    int n = 0;
    for (int k = lo; k <= hi; k++) if (bs[k][i]) n++;
    return n;
  endfunction

  function automatic int cnt_done(int i, int lo, int hi);
    int n = 0;
    for (int k = lo; k <= hi; k++) if (ds[k][i]) n++;
    return n;
  endfunction

  initial begin
    vec_t tbl [8];
    int   kd, ks;
    tbl[0] = '{8'hA5, 1'b0};
    tbl[1] = '{8'h07, 1'b1};
    tbl[2] = '{8'hFF, 1'b0};
    tbl[3] = '{8'h00, 1'b0};
    tbl[4] = '{8'h3C, 1'b0};
    tbl[5] = '{8'h81, 1'b0};
    tbl[6] = '{8'h01, 1'b1};
    tbl[7] = '{8'hFE, 1'b1};

    // Reset held with tx_valid high: nothing accepted, line idle, not ready.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst serial", ser[0], 1'b1);
      chk("rst busy", bsy[0], 1'b0);
      chk("rst done", dn[0], 1'b0);
      chk("rst ready", rdy[0], 1'b0);
    end
    reset = 1'b0;
    valid = 3'b000;
    @(negedge clk);
    chk("ready after reset", rdy[0], 1'b1);

    // Table vectors sent to all three instances at once.
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) din[i] = tbl[v].data;
      valid = 3'b111;
      @(negedge clk);
      valid = 3'b000;
      capture(0, 45);
      chk($sformatf("u0 start %0h", tbl[v].data), ls[2][0], 1'b0);
      chk($sformatf("u0 data %0h", tbl[v].data), get_byte(0, 0, 4), tbl[v].data);
      chk($sformatf("u0 parity %0h", tbl[v].data), ls[38][0], tbl[v].par);
      chk($sformatf("u0 stop %0h", tbl[v].data), ls[42][0], 1'b1);
      chk($sformatf("u0 frame len %0h", tbl[v].data), cnt_busy(0, 0, 44), 44);
      chk($sformatf("u0 done at 44 %0h", tbl[v].data), ds[44][0], 1'b1);
      chk($sformatf("u1 data %0h", tbl[v].data), get_byte(1, 0, 4), tbl[v].data);
      chk($sformatf("u1 stop %0h", tbl[v].data), ls[38][1], 1'b1);
      chk($sformatf("u1 frame len %0h", tbl[v].data), cnt_busy(1, 0, 44), 40);
      chk($sformatf("u1 done count %0h", tbl[v].data), cnt_done(1, 0, 44), 1);
      chk($sformatf("u2 data %0h", tbl[v].data), get_byte(2, 0, 1), tbl[v].data);
      chk($sformatf("u2 parity %0h", tbl[v].data), ls[9][2], tbl[v].par);
      chk($sformatf("u2 frame len %0h", tbl[v].data), cnt_busy(2, 0, 44), 11);
      chk($sformatf("u2 done at 11 %0h", tbl[v].data), ds[11][2], 1'b1);
    end

    // Data hold: new word and valid pulse mid-frame are ignored.
    send(0, 8'h3C);
    capture(0, 10);
    din[0]   = 8'hC3;
    valid[0] = 1'b1;
    chk("hold ready low", rdy[0], 1'b0);
    capture(10, 1);
    valid[0] = 1'b0;
    capture(11, 40);
    chk("hold data", get_byte(0, 0, 4), 8'h3C);
    chk("hold busy cycles", cnt_busy(0, 0, 50), 44);
    chk("hold done count", cnt_done(0, 0, 50), 1);

    // Back-to-back with tx_valid held high.
    @(negedge clk);
    din[0]   = 8'h81;
    valid[0] = 1'b1;
    @(negedge clk);
    din[0] = 8'h18;
    kd = -1;
    ks = -1;
    for (int k = 0; k < 100; k++) begin
      ls[k] = ser; bs[k] = bsy; ds[k] = dn;
      if (k == 50) valid[0] = 1'b0;
      @(negedge clk);
    end
    for (int k = 0; k < 100; k++) if (kd < 0 && ds[k][0]) kd = k;
    for (int k = 0; k < 100; k++) if (kd >= 0 && ks < 0 && k > kd && !ls[k][0]) ks = k;
    chk("b2b first done", kd, 44);
    chk("b2b idle level", ls[44][0], 1'b1);
    chk("b2b gap", ks - kd, 1);
    chk("b2b word1", get_byte(0, 0, 4), 8'h81);
    chk("b2b word2", get_byte(0, 45, 4), 8'h18);
    chk("b2b done count", cnt_done(0, 0, 99), 2);

    // Reset during data bit 3, then a clean frame.
    send(0, 8'hA5);
    capture(0, 17);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst serial", ser[0], 1'b1);
    chk("midrst busy", bsy[0], 1'b0);
    chk("midrst ready", rdy[0], 1'b0);
    reset = 1'b0;
    capture(0, 50);
    chk("midrst no done", cnt_done(0, 0, 49), 0);
    chk("midrst stays idle", cnt_busy(0, 0, 49), 0);
    send(0, 8'h5A);
    capture(0, 45);
    chk("post-rst data", get_byte(0, 0, 4), 8'h5A);
    chk("post-rst parity", ls[38][0], 1'b0);
    chk("post-rst done", cnt_done(0, 0, 44), 1);

    // Random traffic with occasional reset; the per-cycle model checks everything.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < 3; i++) begin
        valid[i] = ($urandom_range(0, 3) != 0);
        din[i]   = 8'($urandom);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    valid = 3'b000;
    repeat (60) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
